// File: rtl/serial_tx_if.sv
// serial_tx_if -- word handshake between a sender and the serial transmitter.
//   TX_VALID : sender offers TX_DATA
//   TX_READY : transmitter can take a word this cycle
//   TX_DATA  : parallel word, WIDTH bits
// A word moves on a rising clock edge where TX_VALID and TX_READY are both 1.
interface serial_tx_if #(
  parameter int WIDTH = 8
);
  logic             TX_VALID;
  logic             TX_READY;
  logic [WIDTH-1:0] TX_DATA;

  modport master (output TX_VALID, output TX_DATA, input TX_READY);
  modport slave  (input TX_VALID, input TX_DATA, output TX_READY);
endinterface

// File: rtl/serial_tx.sv
// serial_tx -- serializes one parallel word per frame onto an idle-high line:
// start bit (0), WIDTH data bits LSB first, optional even-parity bit, stop bit (1).
// Each bit is held for CLKS_PER_BIT cycles.
//   CLK  : rising-edge clock
//   RST  : asynchronous reset, active low
//   tx   : word handshake (slave side: TX_VALID, TX_DATA in; TX_READY out)
//   OUT  : registered serial line, idle high
//   BUSY : frame in progress
//   DONE : registered one-cycle pulse, first cycle back in IDLE
//
// state  | meaning
// IDLE   | line high, TX_READY=1, waiting for a word
// START  | start bit (0)
// DATA   | data bit idx, LSB first
// PARITY | even-parity bit (only with PARITY_EN=1)
// STOP   | stop bit (1), then IDLE
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  serial_tx_if.slave tx,
  output logic       OUT,
  output logic       BUSY,
  output logic       DONE
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [WIDTH-1:0] sh, sh_nxt, sh_shift;
  logic             par, par_nxt;
  logic             out_nxt, done_nxt;
  logic             bit_end;

  assign bit_end     = (cnt == CNT_LAST);
  assign sh_shift    = sh >> 1;
  assign tx.TX_READY = (state == IDLE);
  assign BUSY        = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      par   <= 1'b0;
      OUT   <= 1'b1;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      sh    <= sh_nxt;
      par   <= par_nxt;
      OUT   <= out_nxt;
      DONE  <= done_nxt;
    end
  end

  // OUT is computed one cycle ahead from the next state so the line is a
  // clean flop output that changes exactly on the bit boundary.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    par_nxt   = par;
    out_nxt   = OUT;
    done_nxt  = 1'b0;

    if (state != IDLE) begin
      cnt_nxt = bit_end ? '0 : cnt + CW'(1);
    end

    case (state)
      IDLE: begin
        out_nxt = 1'b1;
        if (tx.TX_VALID) begin
          state_nxt = START;
          sh_nxt    = tx.TX_DATA;
          // Parity is taken from the word as latched, before any shifting.
          par_nxt   = ^tx.TX_DATA;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          out_nxt   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          idx_nxt   = '0;
          out_nxt   = sh[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == IDX_LAST) begin
            if (PARITY_EN) begin
              state_nxt = PARITY;
              out_nxt   = par;
            end else begin
              state_nxt = STOP;
              out_nxt   = 1'b1;
            end
          end else begin
            idx_nxt = idx + IW'(1);
            sh_nxt  = sh_shift;
            out_nxt = sh_shift[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          out_nxt   = 1'b1;
        end
      end
      STOP: begin
        out_nxt = 1'b1;
        if (bit_end) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        out_nxt   = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx -- drives three serial_tx configurations (8/4/no parity,
// 8/4/even parity, 1/1/no parity) and compares OUT, BUSY, TX_READY and DONE
// every cycle against a frame model computed from the bit position k/CLKS_PER_BIT.
module tb_serial_tx;
  logic        CLK;
  logic        RST;
  logic        tx_valid;
  logic [31:0] tx_data;
  int          sel;
  int          vectors;
  int          miscompares;

  int w_of   [3] = '{8, 8, 1};
  int cpb_of [3] = '{4, 4, 1};
  int pe_of  [3] = '{0, 1, 0};

  logic out_a, busy_a, done_a;
  logic out_b, busy_b, done_b;
  logic out_c, busy_c, done_c;
  logic o_out, o_busy, o_done, o_ready;

  serial_tx_if #(.WIDTH(8)) if_a ();
  serial_tx_if #(.WIDTH(8)) if_b ();
  serial_tx_if #(.WIDTH(1)) if_c ();

  assign if_a.TX_VALID = tx_valid && (sel == 0);
  assign if_b.TX_VALID = tx_valid && (sel == 1);
  assign if_c.TX_VALID = tx_valid && (sel == 2);
  assign if_a.TX_DATA  = tx_data[7:0];
  assign if_b.TX_DATA  = tx_data[7:0];
  assign if_c.TX_DATA  = tx_data[0:0];

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_a (
    .CLK(CLK), .RST(RST), .tx(if_a), .OUT(out_a), .BUSY(busy_a), .DONE(done_a));
  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_b (
    .CLK(CLK), .RST(RST), .tx(if_b), .OUT(out_b), .BUSY(busy_b), .DONE(done_b));
  serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u_c (
    .CLK(CLK), .RST(RST), .tx(if_c), .OUT(out_c), .BUSY(busy_c), .DONE(done_c));

  assign o_out   = (sel == 0) ? out_a  : (sel == 1) ? out_b  : out_c;
  assign o_busy  = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  assign o_done  = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
  assign o_ready = (sel == 0) ? if_a.TX_READY : (sel == 1) ? if_b.TX_READY : if_c.TX_READY;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s sel=%0d t=%0t got=%0h exp=%0h", tag, sel, $time, got, exp);
    end
  endtask

  // Expected line level k cycles after the accept edge.
  function automatic logic exp_line(input logic [31:0] d, input int k, input int w,
                                    input int c, input int pe);
    int   b;
    logic p;
    b = k / c;
    if (b == 0) return 1'b0;
    if (b <= w) return d[b-1];
    if (pe != 0 && b == w + 1) begin
      p = 1'b0;
      for (int i = 0; i < w; i++) p ^= d[i];
      return p;
    end
    return 1'b1;
  endfunction

  task automatic set_sel(input int s);
    sel = s;
    #1;
  endtask

  task automatic start(input logic [31:0] d);
    check("ready_pre", 32'(o_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge CLK); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      check("idle_out", 32'(o_out), 32'd1);
      check("idle_busy", 32'(o_busy), 32'd0);
      check("idle_done", 32'(o_done), 32'd0);
    end
  endtask

  // Called just after the accept edge; returns in the DONE cycle (or at abort_k).
  task automatic run_frame(input logic [31:0] d, input bit nv, input logic [31:0] nd,
                           input int poke, input int abort_k);
    int c, w, pe, n;
    c  = cpb_of[sel];
    w  = w_of[sel];
    pe = pe_of[sel];
    n  = (2 + w + pe) * c;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        @(posedge CLK); #1;
      end
      check("out", 32'(o_out), 32'(exp_line(d, k, w, c, pe)));
      check("busy", 32'(o_busy), 32'(k < n));
      check("ready", 32'(o_ready), 32'(k == n));
      check("done", 32'(o_done), 32'(k == n));
      if (k == 0) begin
        tx_valid = nv;
        tx_data  = nd;
      end
      if (poke >= 0 && k == poke) begin
        tx_valid = 1'b1;
        tx_data  = 32'h3C;
      end
      if (poke >= 0 && k == poke + 1) begin
        tx_valid = nv;
        tx_data  = nd;
      end
      if (k == abort_k) return;
    end
  endtask

  logic [31:0] d, nd;
  bit          nv;

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST         = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = '0;
    sel         = 0;
    repeat (2) @(posedge CLK);
    #1;
    for (int s = 0; s < 3; s++) begin
      set_sel(s);
      check("rst_out", 32'(o_out), 32'd1);
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
    end
    @(negedge CLK);
    RST = 1'b1;
    set_sel(0);
    idle_cycles(1);

    // basic frame 0xA5
    start(32'hA5);
    run_frame(32'hA5, 1'b0, 32'h0, -1, -1);
    idle_cycles(1);

    // parity frames
    set_sel(1);
    start(32'hA5);
    run_frame(32'hA5, 1'b0, 32'h0, -1, -1);
    idle_cycles(1);
    start(32'h07);
    run_frame(32'h07, 1'b0, 32'h0, -1, -1);
    idle_cycles(1);

    // back-to-back 0x00 then 0xFF, valid held high
    set_sel(0);
    start(32'h00);
    run_frame(32'h00, 1'b1, 32'hFF, -1, -1);
    @(posedge CLK); #1;
    run_frame(32'hFF, 1'b0, 32'h0, -1, -1);
    idle_cycles(1);

    // busy-ignore: 0x3C offered mid-frame
    start(32'hA5);
    run_frame(32'hA5, 1'b0, 32'hA5, 10, -1);
    idle_cycles(3);

    // reset during data bit 4 (line bit 5)
    start(32'hA5);
    run_frame(32'hA5, 1'b0, 32'h0, -1, 21);
    #1;
    RST = 1'b0;
    #1;
    check("abort_out", 32'(o_out), 32'd1);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    check("abort_ready", 32'(o_ready), 32'd1);
    @(posedge CLK); #1;
    check("abort_hold_out", 32'(o_out), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    idle_cycles(4);
    start(32'h5A);
    run_frame(32'h5A, 1'b0, 32'h0, -1, -1);
    idle_cycles(1);

    // minimum period, WIDTH=1
    set_sel(2);
    start(32'h1);
    run_frame(32'h1, 1'b0, 32'h0, -1, -1);
    idle_cycles(1);
    start(32'h0);
    run_frame(32'h0, 1'b0, 32'h0, -1, -1);
    idle_cycles(1);

    // randomized frames, random gaps and back-to-back chaining
    for (int s = 0; s < 3; s++) begin
      set_sel(s);
      d = $urandom;
      start(d);
      for (int i = 0; i < 10; i++) begin
        nv = (i < 9) && ($urandom_range(0, 1) == 1);
        nd = $urandom;
        run_frame(d, nv, nd, -1, -1);
        if (i == 9) begin
          idle_cycles(1);
        end else if (nv) begin
          @(posedge CLK); #1;
        end else begin
          idle_cycles($urandom_range(1, 3));
          start(nd);
        end
        d = nd;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data bits per frame (legal range 1..32).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, giving CLK cycles per serial bit (legal range >=1).
REQ-003 SHALL have parameter PARITY_EN, default 0; when 1, an even-parity bit is inserted after the data bits.
REQ-004 SHALL have port CLK  input  1  rising-edge clock.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port TX_VALID  input  1  sender offers TX_DATA.
REQ-007 SHALL have port TX_READY  output  1  block can accept a word.
REQ-008 SHALL have port TX_DATA  input  WIDTH  parallel word to serialize.
REQ-009 SHALL have port OUT  output  1  serial line, idle high.
REQ-010 SHALL have port BUSY  output  1  frame in progress.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse on frame completion.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL use a handshake in which a word is accepted on a rising CLK edge where TX_VALID=1 and TX_READY=1.
REQ-014 SHALL drive TX_READY=1 only in IDLE; TX_READY SHALL be a combinational decode of the state register, not of TX_VALID.
REQ-015 SHALL latch TX_DATA into an internal shift register on accept, go to START, and drive OUT=0 from the accept edge.
REQ-016 SHALL hold each serial bit on OUT for exactly CLKS_PER_BIT cycles, using a bit-period counter that counts 0..CLKS_PER_BIT-1 and clears on each state or bit change.
REQ-017 SHALL, in DATA, output WIDTH bits LSB first, using a bit index that counts 0..WIDTH-1.
REQ-018 SHALL, in PARITY (entered only when PARITY_EN=1), output the XOR of all latched data bits, so the total count of ones is even.
REQ-019 SHALL, in STOP, output OUT=1 for CLKS_PER_BIT cycles and then enter IDLE.
REQ-020 SHALL give frame length N = 2+WIDTH+PARITY_EN bits; with accept at edge E0, the return to IDLE SHALL occur at edge E0+N*CLKS_PER_BIT.
REQ-021 SHALL assert DONE for exactly one cycle, the first cycle back in IDLE; DONE SHALL be a registered output.
REQ-022 SHALL hold BUSY=1 in every state except IDLE.
REQ-023 SHALL register OUT; OUT SHALL be 1 in IDLE, with no glitches between bits.
REQ-024 SHALL ignore TX_VALID and TX_DATA changes while BUSY=1; the latched word is unaffected.
REQ-025 SHALL, on back-to-back frames, keep the line in IDLE for at least one cycle (OUT=1) between the end of STOP and the next START.
REQ-026 SHALL, when TX_VALID is already high on the DONE cycle, accept on that edge, so DONE=1 and the new accept coincide.
REQ-027 SHALL, with CLKS_PER_BIT=1, advance one bit per cycle with no skipped or repeated bits.

Reset
REQ-028 SHALL, while RST=0, immediately force: state=IDLE, OUT=1, TX_READY=1, BUSY=0, DONE=0, counters=0, shift register=0.
REQ-029 SHALL, when RST asserts mid-frame, abort the frame with OUT=1 immediately, not retransmit after release, and not pulse DONE.
REQ-030 SHALL, after RST deasserts, accept a word no earlier than the first rising CLK edge with RST=1.

Verification
REQ-031 SHALL verify basic frame: WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=0, send 0xA5 -> OUT=0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles, DONE=1 at edge E0+40, BUSY high over edges E0..E0+39.
REQ-032 SHALL verify parity: PARITY_EN=1, send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1; DONE at E0+44.
REQ-033 SHALL verify back-to-back: TX_VALID held high with 0x00 then 0xFF -> second accept on the DONE cycle, exactly one idle-high cycle between frames, both frames bit-exact.
REQ-034 SHALL verify busy-ignore: TX_DATA changed to 0x3C and TX_VALID pulsed mid-frame -> frame still carries 0xA5, TX_READY stays 0, no extra frame.
REQ-035 SHALL verify reset mid-frame: RST=0 at bit 4 of 0xA5 -> OUT=1, BUSY=0, no DONE; after release, 0x5A sends as a correct full frame.
REQ-036 SHALL verify minimum period: CLKS_PER_BIT=1, WIDTH=1, send 1 -> OUT=0,1,1 on consecutive cycles, DONE at E0+3.
